// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) constants, codeword bit positions and the decode result type.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D3_POS = 2;
  localparam int P4_POS = 3;
  localparam int D5_POS = 4;
  localparam int D6_POS = 5;
  localparam int D7_POS = 6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CODE_W-1:0] code;
    logic [SYN_W-1:0]  syn;
    logic              err;
  } hamming_res_t;

endpackage

// File: rtl/hamming74_syndrome_fix.sv
// Combinational Hamming(7,4) syndrome calculation and single-bit correction.
module hamming74_syndrome_fix
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output hamming_res_t      res
);

  logic [SYN_W-1:0]  syn;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    res    = '0;
    syn[0] = code[P1_POS] ^ code[D3_POS] ^ code[D5_POS] ^ code[D7_POS];
    syn[1] = code[P2_POS] ^ code[D3_POS] ^ code[D6_POS] ^ code[D7_POS];
    syn[2] = code[P4_POS] ^ code[D5_POS] ^ code[D6_POS] ^ code[D7_POS];
    fixed  = code;
    // The syndrome is the 1-based position of the flipped bit.
    if (syn != '0) fixed[syn - 1'b1] = ~code[syn - 1'b1];
    res.data = {fixed[D7_POS], fixed[D6_POS], fixed[D5_POS], fixed[D3_POS]};
    res.code = fixed;
    res.syn  = syn;
    res.err  = |syn;
  end

endmodule

// File: rtl/hamming_rr_decoder_ctrl.sv
// Two-requester round-robin front end sharing one Hamming(7,4) corrector, registered output.
// HAMMING_ERR_CNT_EN adds saturating per-requester corrected-error counters with cnt_clr.
module hamming_rr_decoder_ctrl
  import hamming_pkg::*;
#(
  parameter int NUM_REQ = 2
`ifdef HAMMING_ERR_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [CODE_W-1:0] in0_code,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [CODE_W-1:0] in1_code,
  output logic              in1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CODE_W-1:0] out_code,
  output logic [SYN_W-1:0]  out_syn,
  output logic              out_src,
  output logic              out_err
`ifdef HAMMING_ERR_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1
`endif
);

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] grant;
  logic               last_grant;
  logic               can_load;
  logic [CODE_W-1:0]  sel_code;
  hamming_res_t       fix_res;

  assign valid_vec = {in1_valid, in0_valid};
  assign can_load  = !out_valid || out_ready;

  // Requester 0 wins a tie only when requester 1 was served last.
  always_comb begin
    grant = '0;
    if (can_load && !rst) begin
      if (valid_vec[0] && (!valid_vec[1] || last_grant)) grant[0] = 1'b1;
      else if (valid_vec[1])                             grant[1] = 1'b1;
    end
  end

  assign in0_ready = grant[0];
  assign in1_ready = grant[1];
  assign sel_code  = grant[1] ? in1_code : in0_code;

  hamming74_syndrome_fix u_fix (
    .code (sel_code),
    .res  (fix_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_code   <= '0;
      out_syn    <= '0;
      out_src    <= 1'b0;
      out_err    <= 1'b0;
      last_grant <= 1'b1;
    end else if (can_load) begin
      if (|grant) begin
        out_valid  <= 1'b1;
        out_data   <= fix_res.data;
        out_code   <= fix_res.code;
        out_syn    <= fix_res.syn;
        out_err    <= fix_res.err;
        out_src    <= grant[1];
        last_grant <= grant[1];
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic inc0, inc1;

  assign inc0 = grant[0] && fix_res.err;
  assign inc1 = grant[1] && fix_res.err;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_cnt0 <= '0;
      err_cnt1 <= '0;
    end else begin
      if (inc0 && (err_cnt0 != '1)) err_cnt0 <= err_cnt0 + 1'b1;
      if (inc1 && (err_cnt1 != '1)) err_cnt1 <= err_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_rr_decoder_ctrl.sv
// Scoreboard bench for hamming_rr_decoder_ctrl; expected results come from a nearest-codeword model.
module tb_hamming_rr_decoder_ctrl;

  typedef struct packed {
    logic [3:0] d;
    logic [6:0] c;
    logic [2:0] s;
    logic       e;
    logic       src;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic [6:0] in0_code, in1_code;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [6:0] out_code;
  logic [2:0] out_syn;
  logic       out_src, out_err;
`ifdef HAMMING_ERR_CNT_EN
  localparam int CNT_W = 2;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_cnt0, err_cnt1;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  hamming_rr_decoder_ctrl #(
    .NUM_REQ (2)
`ifdef HAMMING_ERR_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_code  (in0_code),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_code  (in1_code),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_code  (out_code),
    .out_syn   (out_syn),
    .out_src   (out_src),
    .out_err   (out_err)
`ifdef HAMMING_ERR_CNT_EN
    , .cnt_clr  (cnt_clr),
    .err_cnt0  (err_cnt0),
    .err_cnt1  (err_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // Hamming(7,4) is perfect: exactly one codeword lies within distance 1 of any word.
  function automatic exp_t model(input logic [6:0] rx, input logic src);
    exp_t       e;
    logic [6:0] diff;
    e     = '0;
    e.src = src;
    for (int d = 0; d < 16; d++) begin
      diff = rx ^ enc(4'(d));
      if (diff == 7'd0) begin
        e.d = 4'(d);
        e.c = rx;
      end else if ($countones(diff) == 1) begin
        e.d = 4'(d);
        e.c = rx ^ diff;
        e.e = 1'b1;
        for (int b = 0; b < 7; b++) if (diff[b]) e.s = 3'(b + 1);
      end
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: got result data=%h src=%0d, expected none", out_data, out_src);
        end else begin
          mon_e = sb.pop_front();
          if ({out_data, out_code, out_syn, out_err, out_src} !== mon_e) begin
            miscompares++;
            $display("FAIL sb_result: got d=%h c=%b s=%0d e=%0d src=%0d, expected d=%h c=%b s=%0d e=%0d src=%0d",
                     out_data, out_code, out_syn, out_err, out_src,
                     mon_e.d, mon_e.c, mon_e.s, mon_e.e, mon_e.src);
          end
        end
      end
      if (in0_valid && in0_ready) sb.push_back(model(in0_code, 1'b0));
      if (in1_valid && in1_ready) sb.push_back(model(in1_code, 1'b1));
    end
  end

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b1; in0_code = enc(4'h5);
    in1_valid = 1'b1; in1_code = enc(4'hA);
    smp();
    vectors++;
    if ({out_valid, out_data, out_code, out_syn, out_src, out_err} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", {out_valid, out_data, out_code, out_syn, out_src, out_err});
    end
    vectors++;
    if ({in0_ready, in1_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, expected 00", {in0_ready, in1_ready});
    end
    cyc(); rst = 1'b0; sb.delete();
    smp();
    vectors++;
    if ({in0_ready, in1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b, expected 10", {in0_ready, in1_ready});
    end
    cyc(); in0_valid = 1'b0; in1_valid = 1'b0;
    smp();
    vectors++;
    if ({out_valid, out_src} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_src: got %b, expected 10", {out_valid, out_src});
    end
    cyc(); smp();
  endtask

  task automatic test_single_err();
    cyc(); in0_valid = 1'b1; in0_code = 7'b0000001; out_ready = 1'b1;
    smp();
    vectors++;
    if (in0_ready !== 1'b1) begin
      miscompares++; $display("FAIL err0_ready: got %b, expected 1", in0_ready);
    end
    cyc(); in0_valid = 1'b0; in1_valid = 1'b1; in1_code = 7'b0010111;
    smp();
    vectors++;
    if ({out_valid, out_data, out_syn, out_err, out_src, out_code} !== {1'b1, 4'b0000, 3'd1, 1'b1, 1'b0, 7'b0000000}) begin
      miscompares++;
      $display("FAIL err0_result: got v=%b d=%b s=%0d e=%b src=%b c=%b, expected v=1 d=0000 s=1 e=1 src=0 c=0000000",
               out_valid, out_data, out_syn, out_err, out_src, out_code);
    end
    vectors++;
    if (in1_ready !== 1'b1) begin
      miscompares++; $display("FAIL err1_ready: got %b, expected 1", in1_ready);
    end
    cyc(); in1_code = 7'b1000111;
    smp();
    vectors++;
    if ({out_valid, out_data, out_syn, out_src} !== {1'b1, 4'b0001, 3'd5, 1'b1}) begin
      miscompares++;
      $display("FAIL err1_syn5: got v=%b d=%b s=%0d src=%b, expected v=1 d=0001 s=5 src=1", out_valid, out_data, out_syn, out_src);
    end
    cyc(); in1_valid = 1'b0;
    smp();
    vectors++;
    if ({out_data, out_syn, out_code} !== {4'b0001, 3'd7, 7'b0000111}) begin
      miscompares++;
      $display("FAIL err1_syn7: got d=%b s=%0d c=%b, expected d=0001 s=7 c=0000111", out_data, out_syn, out_code);
    end
    cyc(); smp();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL idle_clear: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [6:0] c0 [2];
    logic [6:0] c1 [2];
    int         order [4];
    int         i0, i1, n0, n1;
    c0[0] = enc(4'h3); c0[1] = enc(4'h9);
    c1[0] = enc(4'h5); c1[1] = enc(4'hC);
    order = '{0, 1, 0, 1};
    i0 = 0; i1 = 0; n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      in0_valid = (i0 < 2); in0_code = c0[i0 % 2];
      in1_valid = (i1 < 2); in1_code = c1[i1 % 2];
      out_ready = 1'b1;
      smp();
      vectors++;
      if ({in0_ready, in1_ready} !== {order[k] == 0, order[k] == 1}) begin
        miscompares++;
        $display("FAIL contention_grant%0d: got %b, expected %b", k, {in0_ready, in1_ready}, {order[k] == 0, order[k] == 1});
      end
      if (k > 0) begin
        vectors++;
        if ({out_err, out_src} !== {1'b0, 1'(order[k-1])}) begin
          miscompares++;
          $display("FAIL contention_out%0d: got err=%b src=%b, expected err=0 src=%0d", k, out_err, out_src, order[k-1]);
        end
      end
      if (in0_ready) begin n0++; i0++; end
      if (in1_ready) begin n1++; i1++; end
    end
    cyc(); in0_valid = 1'b0; in1_valid = 1'b0;
    vectors++;
    if (n0 != 2 || n1 != 2) begin
      miscompares++; $display("FAIL contention_pulses: got %0d/%0d, expected 2/2", n0, n1);
    end
    cyc(); smp();
  endtask

  task automatic test_backpressure();
    logic [16:0] snap;
    cyc(); in0_valid = 1'b1; in0_code = enc(4'h6) ^ 7'h20; in1_valid = 1'b0; out_ready = 1'b1;
    smp();
    vectors++;
    if (in0_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_load_ready: got %b, expected 1", in0_ready);
    end
    cyc(); in0_code = enc(4'hA); in1_valid = 1'b1; in1_code = enc(4'h2); out_ready = 1'b0;
    smp();
    snap = {out_valid, out_data, out_code, out_syn, out_src, out_err};
    vectors++;
    if ({out_valid, in0_ready, in1_ready} !== 3'b100) begin
      miscompares++; $display("FAIL bp_stall0: got v/r0/r1=%b, expected 100", {out_valid, in0_ready, in1_ready});
    end
    for (int k = 1; k < 3; k++) begin
      cyc(); smp();
      vectors++;
      if ({out_valid, out_data, out_code, out_syn, out_src, out_err} !== snap || {in0_ready, in1_ready} !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_stall%0d: got out=%h rdy=%b, expected out=%h rdy=00", k,
                 {out_valid, out_data, out_code, out_syn, out_src, out_err}, {in0_ready, in1_ready}, snap);
      end
    end
    cyc(); out_ready = 1'b1;
    smp();
    vectors++;
    if ({in0_ready, in1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_release_grant: got %b, expected 01", {in0_ready, in1_ready});
    end
    cyc(); in1_valid = 1'b0;
    smp();
    vectors++;
    if ({out_valid, out_src, in0_ready} !== 3'b111) begin
      miscompares++; $display("FAIL bp_next_result: got v/src/r0=%b, expected 111", {out_valid, out_src, in0_ready});
    end
    cyc(); in0_valid = 1'b0;
    smp();
    vectors++;
    if ({out_valid, out_src} !== 2'b10) begin
      miscompares++; $display("FAIL bp_final_src: got %b, expected 10", {out_valid, out_src});
    end
    cyc(); smp();
  endtask

  task automatic test_back_to_back();
    logic exp_last, exp_ov, pend0, pend1, can, g0, g1;
    cyc(); rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    cyc(); rst = 1'b0; sb.delete();
    for (int k = 0; k < 8; k++) begin
      in0_valid = 1'b1; in0_code = 7'($urandom);
      smp();
      vectors++;
      if (in0_ready !== 1'b1) begin
        miscompares++; $display("FAIL throughput%0d: got in0_ready=%b, expected 1", k, in0_ready);
      end
      cyc();
    end
    exp_last = 1'b0; exp_ov = 1'b1; pend0 = 1'b0; pend1 = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!pend0 && $urandom_range(0, 9) < 6) begin pend0 = 1'b1; in0_code = 7'($urandom); end
      if (!pend1 && $urandom_range(0, 9) < 6) begin pend1 = 1'b1; in1_code = 7'($urandom); end
      in0_valid = pend0; in1_valid = pend1;
      out_ready = ($urandom_range(0, 3) != 0);
      smp();
      can = !exp_ov || out_ready;
      g0  = can && pend0 && (!pend1 || exp_last);
      g1  = can && pend1 && !g0;
      vectors++;
      if ({in0_ready, in1_ready} !== {g0, g1}) begin
        miscompares++; $display("FAIL random_grant%0d: got %b, expected %b", k, {in0_ready, in1_ready}, {g0, g1});
      end
      if (g0) pend0 = 1'b0;
      if (g1) pend1 = 1'b0;
      if (can) begin
        exp_ov = g0 || g1;
        if (g0 || g1) exp_last = g1;
      end
      cyc();
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); smp();
  endtask

  task automatic test_reset_mid();
    cyc(); in0_valid = 1'b1; in0_code = enc(4'h7); in1_valid = 1'b1; in1_code = enc(4'hB); out_ready = 1'b1;
    cyc(); rst = 1'b1;
    smp();
    vectors++;
    if ({out_valid, in0_ready, in1_ready} !== 3'b100) begin
      miscompares++; $display("FAIL midrst_during: got v/r0/r1=%b, expected 100", {out_valid, in0_ready, in1_ready});
    end
    cyc(); rst = 1'b0; sb.delete();
    smp();
    vectors++;
    if ({out_valid, in0_ready, in1_ready} !== 3'b010) begin
      miscompares++; $display("FAIL midrst_after: got v/r0/r1=%b, expected 010", {out_valid, in0_ready, in1_ready});
    end
    cyc(); in0_valid = 1'b0; in1_valid = 1'b0;
    smp();
    vectors++;
    if ({out_valid, out_src} !== 2'b10) begin
      miscompares++; $display("FAIL midrst_first_src: got %b, expected 10", {out_valid, out_src});
    end
    cyc(); smp();
  endtask

`ifdef HAMMING_ERR_CNT_EN
  task automatic test_err_cnt();
    int exp_c;
    cyc(); in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0;
    smp();
    vectors++;
    if ({err_cnt0, err_cnt1} !== 4'b0000) begin
      miscompares++; $display("FAIL cnt_cleared: got %0d/%0d, expected 0/0", err_cnt0, err_cnt1);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(); in0_valid = 1'b1; in0_code = enc(4'(k)) ^ 7'(1 << k);
      smp();
      exp_c = (k - 1 > 3) ? 3 : k - 1;
      vectors++;
      if (err_cnt0 !== 2'(exp_c)) begin
        miscompares++; $display("FAIL cnt0_step%0d: got %0d, expected %0d", k, err_cnt0, exp_c);
      end
    end
    cyc(); in0_valid = 1'b0;
    smp();
    vectors++;
    if ({err_cnt0, err_cnt1} !== {2'd3, 2'd0}) begin
      miscompares++; $display("FAIL cnt_saturate: got %0d/%0d, expected 3/0", err_cnt0, err_cnt1);
    end
    cyc(); in1_valid = 1'b1; in1_code = enc(4'h9) ^ 7'h40;
    cyc(); in1_valid = 1'b0;
    smp();
    vectors++;
    if (err_cnt1 !== 2'd1) begin
      miscompares++; $display("FAIL cnt1_inc: got %0d, expected 1", err_cnt1);
    end
    cyc(); in0_valid = 1'b1; in0_code = enc(4'h3) ^ 7'h01; cnt_clr = 1'b1;
    cyc(); in0_valid = 1'b0; cnt_clr = 1'b0;
    smp();
    vectors++;
    if ({err_cnt0, err_cnt1} !== 4'b0000) begin
      miscompares++; $display("FAIL cnt_clr_priority: got %0d/%0d, expected 0/0", err_cnt0, err_cnt1);
    end
    cyc(); smp();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_code = '0; in1_code = '0;
`ifdef HAMMING_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_single_err();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef HAMMING_ERR_CNT_EN
    test_err_cnt();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming_rr_decoder_ctrl.md
Name: hamming_rr_decoder_ctrl

Overview:
- Round-robin controller that shares one Hamming(7,4) syndrome/correction datapath between two codeword requesters.
- Each requester presents 7-bit received codewords over a valid/ready handshake. The block arbitrates, corrects single-bit errors, and delivers the 4-bit data nibble, the syndrome and the source ID through a registered output stage with backpressure.
- Sits between link receivers and downstream consumers in the Hamming error-correction subsystem.

Parameters:
- NUM_REQ, 2, number of requesters; fixed at 2 for this revision.
- CNT_W, 8, width of the optional per-channel corrected-error counters.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  requester 0 codeword valid.
- in0_code  input  7  requester 0 codeword; bit0=P1, bit1=P2, bit2=D3, bit3=P4, bit4=D5, bit5=D6, bit6=D7.
- in0_ready  output  1  requester 0 codeword accepted this cycle.
- in1_valid  input  1  requester 1 codeword valid.
- in1_code  input  7  requester 1 codeword, same bit layout as in0_code.
- in1_ready  output  1  requester 1 codeword accepted this cycle.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  4  corrected nibble {D7,D6,D5,D3}.
- out_code  output  7  corrected codeword.
- out_syn  output  3  syndrome {s4,s2,s1}; 0 means no error; otherwise the 1-based bit position that was flipped.
- out_src  output  1  requester ID of the result.
- out_err  output  1  syndrome was nonzero.

Behaviour:
- Reset:
  - out_valid=0; out_data, out_code, out_syn, out_src and out_err are all 0.
  - in0_ready=in1_ready=0 during the reset cycle.
  - last_grant=1, so requester 0 wins the first contention.
- Syndrome:
  - s1 = ^{c[0],c[2],c[4],c[6]}
  - s2 = ^{c[1],c[2],c[5],c[6]}
  - s4 = ^{c[3],c[4],c[5],c[6]}
  - When the syndrome is nonzero, bit c[syn-1] is inverted.
  - The datapath is purely combinational on the granted codeword.
- Accept condition: can_load = !out_valid | out_ready.
- Arbitration, evaluated only when can_load is true:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - in*_ready is asserted combinationally, only for the granted requester.
  - last_grant updates only on an actual grant.
- Register load:
  - On a grant, the output register loads the corrected result with out_valid=1 on the next edge. Latency is 1 cycle from acceptance.
  - When can_load is true and no input is valid: out_valid clears.
  - When can_load is false: all in*_ready=0 and the output is held stable bit-for-bit.
- Throughput: one codeword per cycle when out_ready is held at 1.
- Combinational paths: out_ready to in*_ready exists; there is no combinational path from in*_valid to out_*.
- Reset mid-stream: out_valid drops the cycle after rst is sampled and the in-flight result is discarded. Requesters must re-present data that was not accepted.
- Double-bit errors: the block miscorrects them silently; this is Hamming(7,4) behaviour and is not flagged.

Optional Feature:
- Macro name: HAMMING_ERR_CNT_EN.
- When defined:
  - Adds outputs err_cnt0 and err_cnt1, each CNT_W bits.
  - Adds input cnt_clr.
  - A counter increments when a result with out_err=1 and the matching out_src is loaded into the output register.
  - Counters saturate at all-ones.
  - cnt_clr=1 zeroes both counters synchronously and takes priority over an increment in the same cycle.
  - Both counters reset to 0.
- When undefined: these ports and the counter logic are absent.

Decomposition:
- Shared package hamming_pkg holds:
  - constants CODE_W=7, DATA_W=4 and SYN_W=3;
  - bit-position localparams P1_POS..D7_POS;
  - a packed struct hamming_res_t with fields data, code, syn and err.
- One sub-module, hamming74_syndrome_fix: combinational, taking a codeword and producing hamming_res_t. This controller instantiates it once on the arbiter mux output.

Test Plan:
- Single error, requester 0: in0_code=7'b0000001, out_ready=1 -> one cycle later out_data=4'b0000, out_syn=3'd1, out_err=1, out_src=0, out_code=7'b0000000.
- Single error, requester 1: in1_code=7'b0010111 -> out_data=4'b0001, out_syn=3'd5, out_src=1. Then in1_code=7'b1000111 -> out_data=4'b0001, out_syn=3'd7, out_code=7'b0000111.
- Contention: both requesters valid for 4 cycles with distinct clean codewords, out_ready=1 -> grant order 0,1,0,1; each in*_ready pulses exactly twice; all out_err=0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in0_ready=in1_ready=0. On the release cycle a new grant occurs and the next result follows 1 cycle later.
- Reset mid-stream: assert rst for 1 cycle while out_valid=1 and both requesters valid -> next cycle out_valid=0 and the readies were 0 during the reset cycle. The first post-reset grant goes to requester 0.
- With HAMMING_ERR_CNT_EN defined and CNT_W=2: send 5 erroneous words from requester 0 -> err_cnt0 saturates at 3 and err_cnt1=0. Asserting cnt_clr together with another error -> err_cnt0=0.
